// File: rtl/pwm_timer_ctrl.sv
// Purpose : period counter, prescaler, shadow/active compare-maxval-deadtime
//           registers, break path and update interrupt for the PWM generator.
// Latency : register writes visible next cycle; pwm/pwmn gating is combinational.
// Backpressure: none; every write is accepted in the cycle its strobe is high.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   we, addr, wdata    register write port (one cycle per write)
//   rdata              combinational readback of the register at addr
//   brk                level-sensitive break request
//   pwm_in, pwmn_in    raw generator outputs
//   count, compare,
//   maxval, value      drive the generator
//   pwm_out, pwmn_out  generator outputs gated by the output enable
//   irq                sticky update-event flag (UIF)
module pwm_timer_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        brk,
  input  logic        pwm_in,
  input  logic        pwmn_in,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic [31:0] maxval,
  output logic [7:0]  value,
  output logic        pwm_out,
  output logic        pwmn_out,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_BRK  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        ctrl_en;
  logic        ctrl_arpe;
  logic        ctrl_opm;
  logic [31:0] arr_sh;
  logic [31:0] ccr_sh;
  logic [7:0]  dtg_sh;
  logic [15:0] psc;
  logic [15:0] psc_cnt;
  logic        uif;
  logic        brkf;
  logic        out_en;

  logic wr_ctrl;
  logic wr_arr;
  logic wr_ccr;
  logic wr_dtg;
  logic wr_psc;
  logic wr_status;
  logic counting;
  logic tick;
  logic upd;
  logic start;
  logic brk_clr_ok;

  assign wr_ctrl   = we && (addr == 3'd0);
  assign wr_arr    = we && (addr == 3'd1);
  assign wr_ccr    = we && (addr == 3'd2);
  assign wr_dtg    = we && (addr == 3'd3);
  assign wr_psc    = we && (addr == 3'd4);
  assign wr_status = we && (addr == 3'd5);

  // brk freezes the counter on the very edge it is seen, so it gates counting.
  assign counting   = (state == ST_RUN) && !brk;
  assign tick       = counting && (psc_cnt == psc);
  assign upd        = tick && (count >= maxval);
  assign start      = (state == ST_IDLE) && !brk && wr_ctrl && wdata[0];
  // BRKCLR only takes effect once the break source has gone away.
  assign brk_clr_ok = (state == ST_BRK) && !brk && wr_ctrl && wdata[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (brk) begin
          state_nxt = ST_BRK;
        end else if (start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (brk) begin
          state_nxt = ST_BRK;
        end else if ((wr_ctrl && !wdata[0]) || (upd && ctrl_opm)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BRK: begin
        if (brk_clr_ok) begin
          state_nxt = wdata[0] ? ST_RUN : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign out_en   = (state == ST_RUN);
  assign pwm_out  = pwm_in & out_en;
  assign pwmn_out = pwmn_in & out_en;
  assign irq      = uif;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_arpe <= 1'b0;
      ctrl_opm  <= 1'b0;
      arr_sh    <= 32'd0;
      ccr_sh    <= 32'd0;
      dtg_sh    <= 8'd0;
      psc       <= 16'd0;
      psc_cnt   <= 16'd0;
      count     <= 32'd0;
      maxval    <= 32'd0;
      compare   <= 32'd0;
      value     <= 8'd0;
      uif       <= 1'b0;
      brkf      <= 1'b0;
    end else begin
      // Control bits; one-pulse mode drops EN when the period ends.
      if (wr_ctrl) begin
        ctrl_en   <= wdata[0];
        ctrl_arpe <= wdata[1];
        ctrl_opm  <= wdata[2];
      end
      if (upd && ctrl_opm) begin
        ctrl_en <= 1'b0;
      end

      if (wr_arr) arr_sh <= wdata;
      if (wr_ccr) ccr_sh <= wdata;
      if (wr_dtg) dtg_sh <= wdata[7:0];
      if (wr_psc) psc    <= wdata[15:0];

      // Active registers: bulk load from shadows at start or on a preloaded
      // update event, otherwise direct write-through when preload is off.
      if (start || (upd && ctrl_arpe)) begin
        maxval  <= arr_sh;
        compare <= ccr_sh;
        value   <= dtg_sh;
      end else if (!ctrl_arpe) begin
        if (wr_arr) maxval  <= wdata;
        if (wr_ccr) compare <= wdata;
        if (wr_dtg) value   <= wdata[7:0];
      end

      if (start) begin
        count   <= 32'd0;
        psc_cnt <= 16'd0;
      end else if (counting) begin
        if (tick) begin
          psc_cnt <= 16'd0;
          // >= so a maxval lowered below count still wraps on the next tick.
          count   <= upd ? 32'd0 : count + 32'd1;
        end else begin
          psc_cnt <= psc_cnt + 16'd1;
        end
      end

      // A same-cycle update event beats a software clear.
      if (upd) begin
        uif <= 1'b1;
      end else if (wr_status && wdata[0]) begin
        uif <= 1'b0;
      end

      if (brk) begin
        brkf <= 1'b1;
      end else if (brk_clr_ok) begin
        brkf <= 1'b0;
      end
    end
  end

  // Reads return shadow values; BRKCLR always reads back as 0.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      3'd0:    rdata = {29'd0, ctrl_opm, ctrl_arpe, ctrl_en};
      3'd1:    rdata = arr_sh;
      3'd2:    rdata = ccr_sh;
      3'd3:    rdata = {24'd0, dtg_sh};
      3'd4:    rdata = {16'd0, psc};
      3'd5:    rdata = {30'd0, brkf, uif};
      3'd6:    rdata = count;
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Purpose : directed test of pwm_timer_ctrl with cycle-tagged expectations checked at negedge.
// Latency : expectations are compared in the cycle they are tagged with.
// Backpressure: none; stimulus is driven one register write per cycle.
module tb_pwm_timer_ctrl;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        brk;
    logic        pwm_in;
    logic        pwmn_in;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] maxval;
    logic [7:0]  value;
    logic        pwm_out;
    logic        pwmn_out;
    logic        irq;

    pwm_timer_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .brk      (brk),
        .pwm_in   (pwm_in),
        .pwmn_in  (pwmn_in),
        .count    (count),
        .compare  (compare),
        .maxval   (maxval),
        .value    (value),
        .pwm_out  (pwm_out),
        .pwmn_out (pwmn_out),
        .irq      (irq)
    );

    assign pwm_in  = (count < compare);
    assign pwmn_in = !(count < compare);

    localparam int S_COUNT = 0, S_MAXVAL = 1, S_COMPARE = 2, S_VALUE = 3,
                   S_PWM = 4, S_PWMN = 5, S_IRQ = 6, S_RDATA = 7;

    int unsigned cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    int unsigned q_cyc[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];
    string       q_name[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(input int s);
        case (s)
            S_COUNT:   return count;
            S_MAXVAL:  return maxval;
            S_COMPARE: return compare;
            S_VALUE:   return {24'd0, value};
            S_PWM:     return {31'd0, pwm_out};
            S_PWMN:    return {31'd0, pwmn_out};
            S_IRQ:     return {31'd0, irq};
            default:   return rdata;
        endcase
    endfunction

    task automatic push_exp(input int dly, input int s, input logic [31:0] v, input string n);
        q_cyc.push_back(cyc + dly);
        q_sel.push_back(s);
        q_exp.push_back(v);
        q_name.push_back(n);
    endtask

    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = q_cyc.size() - 1; i >= 0; i--) begin
            if (q_cyc[i] <= cyc) begin
                act = sample(q_sel[i]);
                compared++;
                if (q_cyc[i] != cyc || act !== q_exp[i]) begin
                    mismatched++;
                    $display("FAIL %s @cyc %0d: got %0h, want %0h (due cyc %0d)",
                             q_name[i], cyc, act, q_exp[i], q_cyc[i]);
                end
                q_cyc.delete(i);
                q_sel.delete(i);
                q_exp.delete(i);
                q_name.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        wdata = d;
        step(1);
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] v, input string n);
        addr = a;
        push_exp(0, S_RDATA, v, n);
        step(1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; we = 1'b0; addr = 3'd0; wdata = 32'd0; brk = 1'b0;
        step(2);
        reset = 1'b0;

        push_exp(0, S_COUNT, 0, "rst_count");
        push_exp(0, S_MAXVAL, 0, "rst_maxval");
        push_exp(0, S_COMPARE, 0, "rst_compare");
        push_exp(0, S_VALUE, 0, "rst_value");
        push_exp(0, S_PWM, 0, "rst_pwm");
        push_exp(0, S_PWMN, 0, "rst_pwmn");
        push_exp(0, S_IRQ, 0, "rst_irq");
        step(1);

        compared++;
        if (count !== 32'd0) begin
            mismatched++;
            $display("FAIL direct_rst_count: got %0h, want 0", count);
        end
        compared++;
        if (irq !== 1'b0) begin
            mismatched++;
            $display("FAIL direct_rst_irq: got %0b, want 0", irq);
        end
        compared++;
        if (pwm_out !== 1'b0) begin
            mismatched++;
            $display("FAIL direct_rst_pwm: got %0b, want 0", pwm_out);
        end
        compared++;
        if (pwmn_out !== 1'b0) begin
            mismatched++;
            $display("FAIL direct_rst_pwmn: got %0b, want 0", pwmn_out);
        end

        wr(3'd4, 0);
        wr(3'd1, 4);
        wr(3'd2, 2);
        wr(3'd0, 32'h1);
        push_exp(0, S_MAXVAL, 4, "basic_maxval");
        push_exp(0, S_COMPARE, 2, "basic_compare");
        for (int k = 0; k < 6; k++) begin
            push_exp(k, S_COUNT, k % 5, "basic_count");
            push_exp(k, S_PWM, ((k % 5) < 2) ? 1 : 0, "basic_pwm");
            push_exp(k, S_PWMN, ((k % 5) < 2) ? 0 : 1, "basic_pwmn");
        end
        push_exp(4, S_IRQ, 0, "basic_irq_pre");
        push_exp(5, S_IRQ, 1, "basic_irq_wrap");
        step(6);
        wr(3'd5, 32'h1);
        push_exp(0, S_IRQ, 0, "uif_clear");
        rd(3'd1, 4, "rd_arr");
        wr(3'd0, 0);
        push_exp(0, S_PWM, 0, "stop_pwm");
        push_exp(0, S_PWMN, 0, "stop_pwmn");
        step(1);

        wr(3'd0, 32'h2);
        wr(3'd1, 9);
        wr(3'd2, 5);
        wr(3'd3, 32'h11);
        push_exp(0, S_MAXVAL, 4, "pre_maxval_held");
        push_exp(0, S_VALUE, 0, "pre_value_held");
        rd(3'd1, 9, "pre_rd_shadow");
        wr(3'd0, 32'h3);
        push_exp(0, S_MAXVAL, 9, "pre_start_maxval");
        push_exp(0, S_COMPARE, 5, "pre_start_compare");
        push_exp(0, S_VALUE, 32'h11, "pre_start_value");
        step(5);
        wr(3'd1, 3);
        wr(3'd2, 1);
        wr(3'd3, 32'h22);
        push_exp(0, S_COUNT, 8, "pre_count8");
        push_exp(0, S_MAXVAL, 9, "pre_maxval_old");
        push_exp(0, S_COMPARE, 5, "pre_compare_old");
        push_exp(0, S_VALUE, 32'h11, "pre_value_old");
        push_exp(1, S_COUNT, 9, "pre_count9");
        push_exp(1, S_MAXVAL, 9, "pre_maxval_old9");
        push_exp(2, S_COUNT, 0, "pre_wrap");
        push_exp(2, S_MAXVAL, 3, "pre_maxval_new");
        push_exp(2, S_COMPARE, 1, "pre_compare_new");
        push_exp(2, S_VALUE, 32'h22, "pre_value_new");
        push_exp(5, S_COUNT, 3, "pre_count3");
        push_exp(6, S_COUNT, 0, "pre_wrap2");
        step(6);
        wr(3'd0, 0);

        wr(3'd4, 2);
        wr(3'd1, 1);
        wr(3'd5, 32'h1);
        wr(3'd0, 32'h1);
        push_exp(0, S_COUNT, 0, "psc_c0");
        push_exp(2, S_COUNT, 0, "psc_c2");
        push_exp(3, S_COUNT, 1, "psc_c3");
        push_exp(5, S_COUNT, 1, "psc_c5");
        push_exp(5, S_IRQ, 0, "psc_irq_pre");
        push_exp(6, S_COUNT, 0, "psc_c6");
        push_exp(6, S_IRQ, 1, "psc_irq_wrap");
        push_exp(9, S_COUNT, 1, "psc_c9");
        step(10);
        wr(3'd0, 0);
        wr(3'd4, 0);

        wr(3'd1, 3);
        wr(3'd5, 32'h1);
        wr(3'd0, 32'h5);
        push_exp(0, S_PWM, 1, "opm_pwm_k0");
        push_exp(1, S_PWMN, 1, "opm_pwmn_k1");
        push_exp(3, S_COUNT, 3, "opm_count3");
        push_exp(3, S_IRQ, 0, "opm_irq_pre");
        push_exp(4, S_COUNT, 0, "opm_count_end");
        push_exp(4, S_PWM, 0, "opm_pwm_off");
        push_exp(4, S_PWMN, 0, "opm_pwmn_off");
        push_exp(4, S_IRQ, 1, "opm_irq");
        push_exp(6, S_COUNT, 0, "opm_count_held");
        step(5);
        rd(3'd0, 32'h4, "opm_ctrl_en_cleared");
        step(1);

        wr(3'd1, 9);
        wr(3'd0, 32'h1);
        step(2);
        brk = 1'b1;
        push_exp(0, S_COUNT, 2, "brk_count_at");
        push_exp(0, S_PWMN, 1, "brk_pwmn_same_cycle");
        step(1);
        brk = 1'b0;
        push_exp(0, S_COUNT, 2, "brk_count_frozen");
        push_exp(0, S_PWM, 0, "brk_pwm_off");
        push_exp(0, S_PWMN, 0, "brk_pwmn_off");
        rd(3'd5, 32'h3, "brk_brkf_set");
        brk = 1'b1;
        wr(3'd0, 32'h9);
        brk = 1'b0;
        push_exp(0, S_COUNT, 2, "brkclr_ignored_count");
        push_exp(0, S_PWMN, 0, "brkclr_ignored_pwmn");
        rd(3'd5, 32'h3, "brkclr_ignored_brkf");
        wr(3'd0, 32'h9);
        push_exp(0, S_COUNT, 2, "brk_resume_count");
        push_exp(0, S_PWMN, 1, "brk_resume_pwmn");
        rd(3'd5, 32'h1, "brk_brkf_cleared");
        push_exp(0, S_COUNT, 3, "brk_resume_inc");
        wr(3'd0, 0);

        wr(3'd1, 0);
        wr(3'd5, 32'h1);
        wr(3'd0, 32'h1);
        push_exp(0, S_COUNT, 0, "arr0_c0");
        push_exp(0, S_IRQ, 0, "arr0_irq0");
        push_exp(1, S_COUNT, 0, "arr0_c1");
        push_exp(1, S_IRQ, 1, "arr0_irq1");
        push_exp(2, S_COUNT, 0, "arr0_c2");
        step(3);
        wr(3'd0, 0);

        wr(3'd1, 2);
        wr(3'd5, 32'h1);
        wr(3'd0, 32'h1);
        step(2);
        wr(3'd5, 32'h1);
        push_exp(0, S_IRQ, 1, "uif_set_wins");
        push_exp(0, S_COUNT, 0, "uif_collide_wrap");
        wr(3'd5, 32'h1);
        push_exp(0, S_IRQ, 0, "uif_clear_plain");
        push_exp(0, S_COUNT, 1, "uif_count1");

        reset = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'h1; brk = 1'b1;
        step(1);
        we = 1'b0; brk = 1'b0;
        push_exp(0, S_COUNT, 0, "mrst_count");
        push_exp(0, S_MAXVAL, 0, "mrst_maxval");
        push_exp(0, S_COMPARE, 0, "mrst_compare");
        push_exp(0, S_VALUE, 0, "mrst_value");
        push_exp(0, S_PWM, 0, "mrst_pwm");
        push_exp(0, S_PWMN, 0, "mrst_pwmn");
        push_exp(0, S_IRQ, 0, "mrst_irq");
        step(1);
        reset = 1'b0;
        rd(3'd1, 0, "mrst_rd_arr");
        rd(3'd0, 0, "mrst_rd_ctrl");
        rd(3'd5, 0, "mrst_rd_status");
        step(3);

        for (int i = 0; i < q_cyc.size(); i++) begin
            compared++;
            mismatched++;
            $display("FAIL %s: never checked, want %0h", q_name[i], q_exp[i]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
